// File: rtl/ladder_pkg.sv
// Shared definitions for the X25519 Montgomery-ladder sequencer.
//   state_t : sequencer FSM states
//   P25519  : field prime 2^255 - 19
//   A24     : ladder-step constant (used with BB in the z2 update)
//   clamp() : RFC 7748 scalar clamping
package ladder_pkg;

  typedef enum logic [2:0] {IDLE, SWAP, ISSUE, WAIT, FINAL, DONE} state_t;

  localparam int unsigned FE_W = 256;

  localparam logic [FE_W-1:0] P25519 = (256'd1 << 255) - 256'd19;

  localparam int unsigned A24 = 121666;

  // Clear the cofactor bits, clear bit 255 and force the top ladder bit.
  function automatic logic [FE_W-1:0] clamp(input logic [FE_W-1:0] k);
    logic [FE_W-1:0] r;
    r      = k;
    r[2:0] = 3'b000;
    r[255] = 1'b0;
    r[254] = 1'b1;
    return r;
  endfunction

endpackage

// File: rtl/ladder_cswap.sv
// Constant-time conditional swap of the (x2,z2) and (x3,z3) projective pairs.
//   swap          : 1 exchanges the pairs, 0 passes them through
//   x2,z2,x3,z3   : pairs before the swap
//   x2s..z3s      : pairs after the swap
module ladder_cswap
  import ladder_pkg::*;
#(
  parameter int unsigned W = FE_W
) (
  input  logic         swap,
  input  logic [W-1:0] x2,
  input  logic [W-1:0] z2,
  input  logic [W-1:0] x3,
  input  logic [W-1:0] z3,
  output logic [W-1:0] x2s,
  output logic [W-1:0] z2s,
  output logic [W-1:0] x3s,
  output logic [W-1:0] z3s
);

  // Plain muxes on every bit: timing never depends on the swap value.
  always_comb begin
    x2s = swap ? x3 : x2;
    z2s = swap ? z3 : z2;
    x3s = swap ? x2 : x3;
    z3s = swap ? z2 : z3;
  end

endmodule

// File: rtl/ladder_ctrl.sv
// X25519 Montgomery-ladder sequencer. Captures scalar and base u, runs one
// ladder step per scalar bit (NBITS-1 down to 0) on an external step unit with
// a step_go/step_valid handshake, and returns projective (X2:Z2).
//   clk, rst        : clock, asynchronous active-high reset
//   start           : request, accepted only in IDLE
//   scalar, u_in    : operands captured on an accepted start
//   busy, done      : operation in flight / one-cycle completion pulse
//   x2_out, z2_out  : final projective result
//   step_go         : launches one ladder step
//   step_x1..z3     : step operands (held from step_go until step_valid)
//   step_x2n..z3n   : step results, valid with step_valid
module ladder_ctrl
  import ladder_pkg::*;
#(
  parameter int unsigned NBITS = 255,
  parameter bit          CLAMP = 1'b1,
  parameter int unsigned W     = FE_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] scalar,
  input  logic [W-1:0] u_in,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] x2_out,
  output logic [W-1:0] z2_out,
  output logic         step_go,
  output logic [W-1:0] step_x1,
  output logic [W-1:0] step_x2,
  output logic [W-1:0] step_z2,
  output logic [W-1:0] step_x3,
  output logic [W-1:0] step_z3,
  input  logic [W-1:0] step_x2n,
  input  logic [W-1:0] step_z2n,
  input  logic [W-1:0] step_x3n,
  input  logic [W-1:0] step_z3n,
  input  logic         step_valid
);

  state_t       state_q, state_d;
  logic [W-1:0] k_q, u_q, x2_q, z2_q, x3_q, z3_q;
  logic         swap_q;
  logic [7:0]   t_q;

  logic [W-1:0] k_load, u_load;
  logic         cs_sel;
  logic [W-1:0] x2_s, z2_s, x3_s, z3_s;

  always_comb begin
    k_load      = CLAMP ? clamp(scalar) : scalar;
    u_load      = u_in;
    u_load[255] = 1'b0;
  end

  // FINAL undoes the pending swap; SWAP folds in the current scalar bit.
  assign cs_sel = (state_q == FINAL) ? swap_q : (swap_q ^ k_q[t_q]);

  ladder_cswap #(.W(W)) u_cswap (
    .swap (cs_sel),
    .x2   (x2_q),
    .z2   (z2_q),
    .x3   (x3_q),
    .z3   (z3_q),
    .x2s  (x2_s),
    .z2s  (z2_s),
    .x3s  (x3_s),
    .z3s  (z3_s)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = SWAP;
      SWAP:    state_d = ISSUE;
      ISSUE:   state_d = WAIT;
      WAIT:    if (step_valid) state_d = (t_q == 8'd0) ? FINAL : SWAP;
      FINAL:   state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      k_q     <= '0;
      u_q     <= '0;
      x2_q    <= '0;
      z2_q    <= '0;
      x3_q    <= '0;
      z3_q    <= '0;
      swap_q  <= 1'b0;
      t_q     <= 8'd0;
      x2_out  <= '0;
      z2_out  <= '0;
    end else begin
      state_q <= state_d;
      unique case (state_q)
        IDLE: begin
          if (start) begin
            k_q    <= k_load;
            u_q    <= u_load;
            x2_q   <= W'(1);
            z2_q   <= '0;
            x3_q   <= u_load;
            z3_q   <= W'(1);
            swap_q <= 1'b0;
            t_q    <= 8'(NBITS - 1);
          end
        end
        SWAP: begin
          x2_q   <= x2_s;
          z2_q   <= z2_s;
          x3_q   <= x3_s;
          z3_q   <= z3_s;
          swap_q <= k_q[t_q];
        end
        WAIT: begin
          if (step_valid) begin
            x2_q <= step_x2n;
            z2_q <= step_z2n;
            x3_q <= step_x3n;
            z3_q <= step_z3n;
            if (t_q != 8'd0) t_q <= t_q - 8'd1;
          end
        end
        FINAL: begin
          x2_q   <= x2_s;
          z2_q   <= z2_s;
          x3_q   <= x3_s;
          z3_q   <= z3_s;
          x2_out <= x2_s;
          z2_out <= z2_s;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    busy    = (state_q == SWAP) || (state_q == ISSUE) || (state_q == WAIT) ||
              (state_q == FINAL);
    done    = (state_q == DONE);
    step_go = (state_q == ISSUE);
    step_x1 = u_q;
    step_x2 = x2_q;
    step_z2 = z2_q;
    step_x3 = x3_q;
    step_z3 = z3_q;
  end

endmodule
